// File: rtl/mouse_packet_tracker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : mouse_packet_tracker
// Brief   : Frames 3/4-byte PS/2 mouse packets; clamped cursor, buttons, wheel.
// Revision: 1.0
//==============================================================================
module mouse_packet_tracker #(
  parameter int COORD_W    = 10,
  parameter int XMIN       = 0,
  parameter int XMAX       = 159,
  parameter int YMIN       = 0,
  parameter int YMAX       = 119,
  parameter int XSTART     = 79,
  parameter int YSTART     = 59,
  parameter int WHEEL_EN   = 0,
  parameter int SHIFT      = 0,
  parameter int TIMEOUT    = 50000,
  parameter int INIT_BYTES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_tracking,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               left_click,
  output logic               right_click,
  output logic               middle_click,
  output logic [3:0]         wheel_delta,
  output logic               packet_valid,
  output logic               sync_error,
  output logic [7:0]         packet_count
);

  localparam int c_DW = COORD_W + 4;
  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);
  localparam logic [7:0] c_ILAST = 8'(INIT_BYTES - 1);
  localparam logic signed [c_DW-1:0] c_XMIN = c_DW'(XMIN);
  localparam logic signed [c_DW-1:0] c_XMAX = c_DW'(XMAX);
  localparam logic signed [c_DW-1:0] c_YMIN = c_DW'(YMIN);
  localparam logic signed [c_DW-1:0] c_YMAX = c_DW'(YMAX);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_B1     = 3'd1,
    S_B2     = 3'd2,
    S_B3     = 3'd3,
    S_B4     = 3'd4,
    S_UPDATE = 3'd5
  } state_t;

  state_t             r_state;
  logic [7:0]         r_init_cnt;
  logic [c_TW-1:0]    r_idle_cnt;
  logic [1:0]         r_ovf;
  logic [1:0]         r_sign;
  logic [2:0]         r_btn;
  logic [7:0]         r_dx;
  logic [7:0]         r_dy;
  logic [3:0]         r_wheel;
  logic               r_commit;
  logic [COORD_W-1:0] r_nx;
  logic [COORD_W-1:0] r_ny;
  logic [2:0]         r_pend_btn;
  logic [3:0]         r_pend_wheel;
  logic               r_sync_hold;

  logic signed [8:0]      w_dx9;
  logic signed [8:0]      w_dy9;
  logic signed [c_DW-1:0] w_dx;
  logic signed [c_DW-1:0] w_dy;
  logic signed [c_DW-1:0] w_nx;
  logic signed [c_DW-1:0] w_ny;
  logic [COORD_W-1:0]     w_cx;
  logic [COORD_W-1:0]     w_cy;
  logic                   w_in_body;
  logic                   w_timeout;
  logic                   w_sync_evt;

  assign w_dx9 = {r_sign[0], r_dx};
  assign w_dy9 = {r_sign[1], r_dy};
  assign w_dx  = {{(c_DW-9){w_dx9[8]}}, w_dx9} <<< SHIFT;
  assign w_dy  = {{(c_DW-9){w_dy9[8]}}, w_dy9} <<< SHIFT;
  assign w_nx  = $signed({4'b0000, x_pos}) + w_dx;
  // Mouse Y grows upward, screen Y grows downward.
  assign w_ny  = $signed({4'b0000, y_pos}) - w_dy;

  always_comb begin
    w_cx = w_nx[COORD_W-1:0];
    w_cy = w_ny[COORD_W-1:0];
    if (w_nx < c_XMIN) w_cx = c_XMIN[COORD_W-1:0];
    else if (w_nx > c_XMAX) w_cx = c_XMAX[COORD_W-1:0];
    if (w_ny < c_YMIN) w_cy = c_YMIN[COORD_W-1:0];
    else if (w_ny > c_YMAX) w_cy = c_YMAX[COORD_W-1:0];
  end

  assign w_in_body  = (r_state == S_B2) || (r_state == S_B3) || (r_state == S_B4);
  assign w_timeout  = w_in_body && !rx_valid && (r_idle_cnt == c_TLAST);
  assign w_sync_evt = w_timeout ||
                      (((r_state == S_B1) || (r_state == S_UPDATE)) && rx_valid && !rx_data[3]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_ovf        <= '0;
      r_sign       <= '0;
      r_btn        <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_wheel      <= '0;
      r_commit     <= 1'b0;
      r_nx         <= COORD_W'(XSTART);
      r_ny         <= COORD_W'(YSTART);
      r_pend_btn   <= '0;
      r_pend_wheel <= '0;
      r_sync_hold  <= 1'b0;
      x_pos        <= COORD_W'(XSTART);
      y_pos        <= COORD_W'(YSTART);
      left_click   <= 1'b0;
      right_click  <= 1'b0;
      middle_click <= 1'b0;
      wheel_delta  <= '0;
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      packet_count <= '0;
    end else begin
      r_commit <= 1'b0;

      if (rx_valid || !w_in_body || w_timeout) r_idle_cnt <= '0;
      else                                     r_idle_cnt <= r_idle_cnt + 1'b1;

      case (r_state)
        S_INIT: begin
          if (INIT_BYTES == 0) begin
            r_state <= S_B1;
          end else if (rx_valid) begin
            if (r_init_cnt == c_ILAST) begin
              r_init_cnt <= '0;
              r_state    <= S_B1;
            end else begin
              r_init_cnt <= r_init_cnt + 1'b1;
            end
          end
        end
        S_B1, S_UPDATE: begin
          if (r_state == S_UPDATE) begin
            // Stage the packet; it becomes visible on the next edge.
            r_commit     <= 1'b1;
            r_nx         <= (r_ovf[0] || !enable_tracking) ? x_pos : w_cx;
            r_ny         <= (r_ovf[1] || !enable_tracking) ? y_pos : w_cy;
            r_pend_btn   <= r_btn;
            r_pend_wheel <= (WHEEL_EN != 0) ? r_wheel : 4'd0;
            r_state      <= S_B1;
          end
          if (rx_valid && rx_data[3]) begin
            r_ovf   <= rx_data[7:6];
            r_sign  <= rx_data[5:4];
            r_btn   <= rx_data[2:0];
            r_state <= S_B2;
          end
        end
        S_B2: begin
          if (rx_valid) begin
            r_dx    <= rx_data;
            r_state <= S_B3;
          end else if (w_timeout) begin
            r_state <= S_B1;
          end
        end
        S_B3: begin
          if (rx_valid) begin
            r_dy    <= rx_data;
            r_state <= (WHEEL_EN != 0) ? S_B4 : S_UPDATE;
          end else if (w_timeout) begin
            r_state <= S_B1;
          end
        end
        S_B4: begin
          if (rx_valid) begin
            r_wheel <= rx_data[3:0];
            r_state <= S_UPDATE;
          end else if (w_timeout) begin
            r_state <= S_B1;
          end
        end
        default: r_state <= S_INIT;
      endcase

      if (r_commit) begin
        x_pos        <= r_nx;
        y_pos        <= r_ny;
        left_click   <= r_pend_btn[0];
        right_click  <= r_pend_btn[1];
        middle_click <= r_pend_btn[2];
        wheel_delta  <= r_pend_wheel;
        packet_count <= packet_count + 1'b1;
      end
      packet_valid <= r_commit;

      // A sync error coinciding with a commit is deferred one cycle so the pulses never overlap.
      sync_error  <= (w_sync_evt || r_sync_hold) && !r_commit;
      r_sync_hold <= (w_sync_evt || r_sync_hold) && r_commit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mouse_packet_tracker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : tb_mouse_packet_tracker
// Brief   : Directed scoreboard bench for 3-byte and wheel-mode trackers.
// Revision: 1.0
//==============================================================================
module tb_mouse_packet_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable_tracking = 1'b1;
  logic       sel = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clock = ~clock;

  logic       v0, v1;
  logic [9:0] x0, y0, x1, y1;
  logic       l0, r0, m0, l1, r1, m1, pv0, pv1, se0, se1;
  logic [3:0] w0, w1;
  logic [7:0] c0, c1;

  assign v0 = rx_valid && !sel;
  assign v1 = rx_valid && sel;

  mouse_packet_tracker #(.TIMEOUT(20)) u_dut0 (
    .clock(clock), .reset(reset), .enable_tracking(enable_tracking),
    .rx_data(rx_data), .rx_valid(v0),
    .x_pos(x0), .y_pos(y0), .left_click(l0), .right_click(r0), .middle_click(m0),
    .wheel_delta(w0), .packet_valid(pv0), .sync_error(se0), .packet_count(c0)
  );

  mouse_packet_tracker #(.WHEEL_EN(1), .SHIFT(1), .INIT_BYTES(0)) u_dut1 (
    .clock(clock), .reset(reset), .enable_tracking(enable_tracking),
    .rx_data(rx_data), .rx_valid(v1),
    .x_pos(x1), .y_pos(y1), .left_click(l1), .right_click(r1), .middle_click(m1),
    .wheel_delta(w1), .packet_valid(pv1), .sync_error(se1), .packet_count(c1)
  );

  logic [9:0] ox, oy;
  logic       ol, or_, om, opv, ose;
  logic [3:0] ow;
  logic [7:0] oc;
  assign ox  = sel ? x1  : x0;
  assign oy  = sel ? y1  : y0;
  assign ol  = sel ? l1  : l0;
  assign or_ = sel ? r1  : r0;
  assign om  = sel ? m1  : m0;
  assign ow  = sel ? w1  : w0;
  assign opv = sel ? pv1 : pv0;
  assign ose = sel ? se1 : se0;
  assign oc  = sel ? c1  : c0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       l;
    logic       r;
    logic       m;
    logic [3:0] w;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_pkt(input int x, input int y, input bit l, input bit r, input bit m,
                            input int w, input int cnt);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.l = l; e.r = r; e.m = m; e.w = 4'(w); e.cnt = 8'(cnt);
    sb.push_back(e);
  endtask

  // Called one ns after the final byte's edge k: outputs must move at edge k+2 exactly.
  task automatic finish_packet(input string tag);
    exp_t e;
    check({tag, "_pv_k"}, 32'(opv), 0);
    tick();
    check({tag, "_pv_k1"}, 32'(opv), 0);
    tick();
    check({tag, "_pv_k2"}, 32'(opv), 1);
    check({tag, "_se_excl"}, 32'(ose), 0);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_x"}, 32'(ox), 32'(e.x));
      check({tag, "_y"}, 32'(oy), 32'(e.y));
      check({tag, "_btn"}, {29'd0, om, or_, ol}, {29'd0, e.m, e.r, e.l});
      check({tag, "_wheel"}, 32'(ow), 32'(e.w));
      check({tag, "_count"}, 32'(oc), 32'(e.cnt));
    end
    tick();
    check({tag, "_pv_k3"}, 32'(opv), 0);
  endtask

  task automatic send3(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
    finish_packet(tag);
  endtask

  task automatic send4(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    finish_packet(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and basic packet after init bytes
    sel = 1'b0;
    do_reset();
    check("rst_x", 32'(ox), 79);
    check("rst_y", 32'(oy), 59);
    check("rst_cnt", 32'(oc), 0);
    check("rst_pulses", {30'd0, opv, ose}, 0);
    check("rst_btn", {29'd0, om, or_, ol}, 0);
    send_byte(8'hFA);
    send_byte(8'hAA);
    check("init_no_sync", 32'(ose), 0);
    expect_pkt(84, 56, 0, 0, 0, 0, 1);
    send3("basic", 8'h08, 8'h05, 8'h03);

    // X clamps at both ends
    do_reset();
    send_byte(8'hFA); send_byte(8'hAA);
    expect_pkt(0, 59, 0, 0, 0, 0, 1);
    send3("xmin", 8'h18, 8'hB0, 8'h00);
    expect_pkt(127, 59, 0, 0, 0, 0, 2);
    send3("xmid", 8'h08, 8'h7F, 8'h00);
    expect_pkt(159, 59, 0, 0, 0, 0, 3);
    send3("xmax", 8'h08, 8'h7F, 8'h00);

    // Y clamp and overflow flags
    expect_pkt(159, 119, 0, 0, 0, 0, 4);
    send3("ymax", 8'h28, 8'h00, 8'h9C);
    expect_pkt(159, 119, 0, 0, 0, 0, 5);
    send3("xovf", 8'h58, 8'hB0, 8'h00);
    expect_pkt(159, 119, 0, 0, 0, 0, 6);
    send3("yovf", 8'h88, 8'h00, 8'h10);

    // Bad byte1 dropped, then buttons
    do_reset();
    send_byte(8'hFA); send_byte(8'hAA);
    send_byte(8'h05);
    check("sync_pulse", 32'(ose), 1);
    tick();
    check("sync_end", 32'(ose), 0);
    check("sync_noupd_x", 32'(ox), 79);
    check("sync_noupd_cnt", 32'(oc), 0);
    expect_pkt(80, 58, 1, 0, 0, 0, 1);
    send3("left", 8'h09, 8'h01, 8'h01);
    expect_pkt(80, 58, 0, 1, 0, 0, 2);
    send3("right", 8'h0A, 8'h00, 8'h00);

    // Timeout discard
    do_reset();
    send_byte(8'hFA); send_byte(8'hAA);
    send_byte(8'h08);
    repeat (19) tick();
    check("to_early", 32'(ose), 0);
    tick();
    check("to_pulse", 32'(ose), 1);
    tick();
    check("to_end", 32'(ose), 0);
    expect_pkt(81, 59, 0, 0, 0, 0, 1);
    send3("after_to", 8'h08, 8'h02, 8'h00);

    // Reset mid-packet
    send_byte(8'h08);
    send_byte(8'h05);
    do_reset();
    check("midrst_x", 32'(ox), 79);
    check("midrst_cnt", 32'(oc), 0);
    send_byte(8'hFA); send_byte(8'hAA);
    expect_pkt(80, 59, 0, 0, 0, 0, 1);
    send3("post_rst", 8'h08, 8'h01, 8'h00);

    // Tracking disabled: position holds, buttons still update
    enable_tracking = 1'b0;
    expect_pkt(80, 59, 1, 0, 0, 0, 2);
    send3("frozen", 8'h09, 8'h10, 8'h10);
    enable_tracking = 1'b1;

    // Wheel mode with gain x2, no init bytes
    sel = 1'b1;
    do_reset();
    tick();
    check("w_rst_x", 32'(ox), 79);
    expect_pkt(83, 59, 0, 0, 1, 15, 1);
    send4("wheel", 8'h0C, 8'h02, 8'h00, 8'h0F);
    enable_tracking = 1'b0;
    expect_pkt(83, 59, 0, 0, 0, 1, 2);
    send4("w_frozen", 8'h08, 8'h10, 8'h10, 8'h01);
    enable_tracking = 1'b1;
    expect_pkt(159, 49, 0, 0, 0, 0, 3);
    send4("w_gain", 8'h08, 8'h40, 8'h05, 8'h00);

    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
